ram_fifo_ctrl: RTL and testbench

- Synchronous FIFO controller that sits directly upstream of the team's 64x8 dual-address single-clock RAM (registered read, 1-cycle latency).
- Turns push/pop requests into `we`, `write_addr` and `read_addr` for the RAM.
- Tracks occupancy and flags full/empty.
- Asserts `rd_valid` in the cycle the RAM's registered `data_out` holds the popped word.

---
 rtl/ram_fifo_ctrl_if.sv | 39 +++
 rtl/ram_fifo_ctrl.sv | 83 ++++++++
 tb/tb_ram_fifo_ctrl.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/ram_fifo_ctrl_if.sv
// Handshake/status bundle between a FIFO producer/consumer and ram_fifo_ctrl.
// With ALMOST_FLAGS_EN defined the bundle also carries almost_full/almost_empty.
interface ram_fifo_ctrl_if #(
    parameter int ADDR_W = 6
);
    logic              push;
    logic              pop;
    logic              we;
    logic [ADDR_W-1:0] write_addr;
    logic [ADDR_W-1:0] read_addr;
    logic              rd_valid;
    logic              full;
    logic              empty;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic              underflow;
`ifdef ALMOST_FLAGS_EN
    logic              almost_full;
    logic              almost_empty;
`endif

    modport master (
        output push, pop,
        input  we, write_addr, read_addr, rd_valid, full, empty, count,
`ifdef ALMOST_FLAGS_EN
        input  almost_full, almost_empty,
`endif
        input  overflow, underflow
    );

    modport slave (
        input  push, pop,
        output we, write_addr, read_addr, rd_valid, full, empty, count,
`ifdef ALMOST_FLAGS_EN
        output almost_full, almost_empty,
`endif
        output overflow, underflow
    );
endinterface

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller driving a single-clock RAM with 1-cycle registered read.
// Optional almost_full/almost_empty flags are enabled by defining ALMOST_FLAGS_EN.
module ram_fifo_ctrl #(
    parameter int ADDR_W   = 6,
    parameter int AF_LEVEL = 60,
    parameter int AE_LEVEL = 4
) (
    input  logic           clk,
    input  logic           rst,
    ram_fifo_ctrl_if.slave bus
);
    localparam int              DEPTH   = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [ADDR_W:0]   count_q, count_nxt;
    logic              full_q, empty_q;
    logic              rd_valid_q, overflow_q, underflow_q;
    logic              do_wr, do_rd;

    // Acceptance only looks at registered flags, so no push/pop-to-flag comb path.
    assign do_wr = bus.push & ~full_q;
    assign do_rd = bus.pop  & ~empty_q;

    always_comb begin
        count_nxt = count_q;
        case ({do_wr, do_rd})
            2'b10:   count_nxt = count_q + 1'b1;
            2'b01:   count_nxt = count_q - 1'b1;
            default: count_nxt = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            count_q     <= count_nxt;
            // Pointers coincide both when full and empty; count disambiguates.
            full_q      <= (count_nxt == DEPTH_C);
            empty_q     <= (count_nxt == '0);
            rd_valid_q  <= do_rd;
            overflow_q  <= bus.push & full_q;
            underflow_q <= bus.pop & empty_q;
        end
    end

`ifdef ALMOST_FLAGS_EN
    logic almost_full_q, almost_empty_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            almost_full_q  <= 1'b0;
            almost_empty_q <= 1'b1;
        end else begin
            almost_full_q  <= (count_nxt >= (ADDR_W+1)'(AF_LEVEL));
            almost_empty_q <= (count_nxt <= (ADDR_W+1)'(AE_LEVEL));
        end
    end

    assign bus.almost_full  = almost_full_q;
    assign bus.almost_empty = almost_empty_q;
`endif

    assign bus.we         = do_wr;
    assign bus.write_addr = wr_ptr;
    assign bus.read_addr  = rd_ptr;
    assign bus.rd_valid   = rd_valid_q;
    assign bus.full       = full_q;
    assign bus.empty      = empty_q;
    assign bus.count      = count_q;
    assign bus.overflow   = overflow_q;
    assign bus.underflow  = underflow_q;
endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Randomized bench for ram_fifo_ctrl: a queue-based FIFO model plus a RAM model,
// compared every cycle, with directed literal checks pinning the model.
module tb_ram_fifo_ctrl;
    localparam int ADDR_W = 6;
    localparam int DEPTH  = 64;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ram_fifo_ctrl_if #(.ADDR_W(ADDR_W)) bus();
    ram_fifo_ctrl #(.ADDR_W(ADDR_W), .AF_LEVEL(60), .AE_LEVEL(4)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    // 64x8 RAM with registered read, as seen downstream of the controller
    logic [7:0] din, dout;
    logic [7:0] mem [DEPTH];
    always @(posedge clk) begin
        if (bus.we) mem[bus.write_addr] <= din;
        dout <= mem[bus.read_addr];
    end

    int passed = 0;
    int total  = 0;

    task automatic chk(string nm, int act, int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    endtask

    // Behavioural model: contents as a queue, pointers as accepted-op totals
    logic [7:0] q[$];
    int         wr_n, rd_n;
    bit         m_rv, m_ov, m_un;
    logic [7:0] m_data;

    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            wr_n = 0; rd_n = 0;
            m_rv = 0; m_ov = 0; m_un = 0;
        end else begin
            m_ov = bus.push && (q.size() == DEPTH);
            m_un = bus.pop  && (q.size() == 0);
            m_rv = bus.pop  && (q.size() != 0);
            if (m_rv) begin
                m_data = q.pop_front();
                rd_n++;
            end
            if (bus.push && !m_ov) begin
                q.push_back(din);
                wr_n++;
            end
        end
        #1;
        chk("count",      int'(bus.count),      q.size());
        chk("full",       int'(bus.full),       int'(q.size() == DEPTH));
        chk("empty",      int'(bus.empty),      int'(q.size() == 0));
        chk("rd_valid",   int'(bus.rd_valid),   int'(m_rv));
        chk("overflow",   int'(bus.overflow),   int'(m_ov));
        chk("underflow",  int'(bus.underflow),  int'(m_un));
        chk("write_addr", int'(bus.write_addr), wr_n % DEPTH);
        chk("read_addr",  int'(bus.read_addr),  rd_n % DEPTH);
        chk("we",         int'(bus.we),         int'(bus.push && (q.size() < DEPTH)));
        if (m_rv) chk("data_out", int'(dout), int'(m_data));
`ifdef ALMOST_FLAGS_EN
        chk("almost_full",  int'(bus.almost_full),  int'(q.size() >= 60));
        chk("almost_empty", int'(bus.almost_empty), int'(q.size() <= 4));
`endif
    end

    task automatic step(bit p, bit o, logic [7:0] d);
        @(negedge clk);
        bus.push = p; bus.pop = o; din = d;
        @(posedge clk);
        #2;
    endtask

    task automatic do_rst(bit p);
        @(negedge clk);
        rst = 1'b1; bus.push = p; bus.pop = 1'b0; din = 8'hEE;
        @(posedge clk);
        #2;
        @(negedge clk);
        rst = 1'b0; bus.push = 1'b0;
    endtask

    initial begin
        rst = 1'b1; bus.push = 1'b0; bus.pop = 1'b0; din = 8'h00;
        do_rst(1'b0);

        repeat (3) step(0, 0, 8'h00);
        chk("lit_rst_empty", int'(bus.empty), 1);
        chk("lit_rst_full",  int'(bus.full), 0);
        chk("lit_rst_count", int'(bus.count), 0);
        chk("lit_rst_rv",    int'(bus.rd_valid), 0);
        chk("lit_rst_waddr", int'(bus.write_addr), 0);
        chk("lit_rst_raddr", int'(bus.read_addr), 0);

        step(1, 0, 8'hA1); step(1, 0, 8'hB2); step(1, 0, 8'hC3);
        chk("lit_count3", int'(bus.count), 3);
        step(0, 1, 8'h00);
        chk("lit_pop1_rv", int'(bus.rd_valid), 1);
        chk("lit_pop1",    int'(dout), 8'hA1);
        step(0, 1, 8'h00);
        chk("lit_pop2",    int'(dout), 8'hB2);
        step(0, 1, 8'h00);
        chk("lit_pop3",    int'(dout), 8'hC3);
        chk("lit_count0",  int'(bus.count), 0);
        step(0, 0, 8'h00);
        chk("lit_idle_rv", int'(bus.rd_valid), 0);
        chk("lit_end_empty", int'(bus.empty), 1);

        // Fill from reset to full, then one push too many
        do_rst(1'b0);
        for (int i = 0; i < DEPTH; i++) step(1, 0, 8'($urandom));
        chk("lit_full",       int'(bus.full), 1);
        chk("lit_count64",    int'(bus.count), 64);
        @(negedge clk);
        bus.push = 1'b1; bus.pop = 1'b0; din = 8'h77;
        #1;
        chk("lit_we_full", int'(bus.we), 0);
        @(posedge clk);
        #2;
        chk("lit_overflow",   int'(bus.overflow), 1);
        chk("lit_waddr_wrap", int'(bus.write_addr), 0);
        step(0, 0, 8'h00);
        chk("lit_overflow_pulse", int'(bus.overflow), 0);
        for (int i = 0; i < DEPTH; i++) step(0, 1, 8'h00);

        // Pop on empty with a simultaneous push
        do_rst(1'b0);
        step(1, 1, 8'h5A);
        chk("lit_underflow", int'(bus.underflow), 1);
        chk("lit_uf_rv",     int'(bus.rd_valid), 0);
        chk("lit_uf_count",  int'(bus.count), 1);
        step(0, 1, 8'h00);
        chk("lit_uf_rv2",    int'(bus.rd_valid), 1);
        chk("lit_uf_data",   int'(dout), 8'h5A);

        // Move pointers near the wrap, hold 10 entries under push+pop streaming
        for (int i = 0; i < 55; i++) step(1, 0, 8'($urandom));
        for (int i = 0; i < 55; i++) step(0, 1, 8'h00);
        for (int i = 0; i < 10; i++) step(1, 0, 8'($urandom));
        for (int i = 0; i < 20; i++) step(1, 1, 8'($urandom));
        chk("lit_stream_count", int'(bus.count), 10);
        chk("lit_stream_raddr", int'(bus.read_addr), 12);

        // Reset with push asserted must not record a write
        for (int i = 0; i < 20; i++) step(1, 0, 8'($urandom));
        chk("lit_count30", int'(bus.count), 30);
        do_rst(1'b1);
        chk("lit_rst_push_count", int'(bus.count), 0);
        chk("lit_rst_push_empty", int'(bus.empty), 1);
        chk("lit_rst_push_waddr", int'(bus.write_addr), 0);
        step(1, 0, 8'h3C);
        step(0, 1, 8'h00);
        chk("lit_after_rst_data", int'(dout), 8'h3C);

`ifdef ALMOST_FLAGS_EN
        do_rst(1'b0);
        chk("lit_ae_rst", int'(bus.almost_empty), 1);
        chk("lit_af_rst", int'(bus.almost_full), 0);
        for (int i = 0; i < 4; i++) step(1, 0, 8'($urandom));
        chk("lit_ae_4", int'(bus.almost_empty), 1);
        step(1, 0, 8'($urandom));
        chk("lit_ae_5", int'(bus.almost_empty), 0);
        for (int i = 0; i < 55; i++) step(1, 0, 8'($urandom));
        chk("lit_af_60", int'(bus.almost_full), 1);
        step(0, 1, 8'h00);
        chk("lit_af_59", int'(bus.almost_full), 0);
`endif

        // Randomized phases: fill-biased, drain-biased, balanced, saturating
        do_rst(1'b0);
        for (int ph = 0; ph < 4; ph++) begin
            int pp, pq;
            case (ph)
                0: begin pp = 75; pq = 30; end
                1: begin pp = 30; pq = 75; end
                2: begin pp = 50; pq = 50; end
                default: begin pp = 90; pq = 85; end
            endcase
            for (int i = 0; i < 600; i++) begin
                if ($urandom_range(399) == 0) do_rst(1'($urandom_range(1)));
                else step($urandom_range(99) < pp, $urandom_range(99) < pq, 8'($urandom));
            end
        end
        step(0, 0, 8'h00);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
